instr_fetch_ctrl: RTL
=====================

// Module: instr_fetch_ctrl
// PURPOSE
//  IF-stage controller that sequences the instruction ROM in the 5-stage MIPS pipeline.
//  Owns the PC and the IF/ID register.
//  Drives the ROM word address, applies hazard stalls and ID-stage branch/jump redirects with
//  MIPS delay-slot semantics, and halts fetch on out-of-range or misaligned PCs.
// PARAMETERS
//  PC_RESET  32'h0000_3000  PC value loaded on reset
//  ROM_BASE  32'h0000_3000  byte address of ROM word 0
//  ROM_AW    10             ROM word-address width (2^ROM_AW words)
// PORTS
//  clk            in   1       clock; all state updates on posedge
//  reset          in   1       synchronous, active-high reset
//  stall_i        in   1       hazard unit: hold PC and IF/ID this cycle
//  redirect_i     in   1       ID stage: branch taken / jump
//  redirect_pc_i  in   32      target PC for redirect_i
//  rom_addr_o     out  ROM_AW  word address to ROM (combinational read)
//  rom_data_i     in   32      ROM read data for rom_addr_o
//  pc_o           out  32      PC of instruction currently in IF
//  if_id_instr_o  out  32      IF/ID instruction
//  if_id_pc_o     out  32      IF/ID PC
//  if_id_pc8_o    out  32      IF/ID PC+8 (jal/jalr link value)
//  if_id_valid_o  out  1       IF/ID holds a real fetched instruction
//  fetch_err_o    out  1       sticky: fetch halted on bad PC
//  fetch_cnt_o    out  32      number of instructions delivered to ID
// BEHAVIOUR
//  - Reset values:
//    - pc = PC_RESET, if_id_instr = 0 (nop), if_id_pc = PC_RESET, if_id_pc8 = PC_RESET+8.
//    - if_id_valid = 0, fetch_err = 0, fetch_cnt = 0, state = RUN.
//  - Reset overrides everything, including HALT and stall.
//  - rom_addr_o = (pc - ROM_BASE)[ROM_AW+1:2], purely combinational from pc.
//  - bad_pc = (pc[1:0] != 0) | (pc < ROM_BASE) | (pc >= ROM_BASE + 4*2^ROM_AW).
//    - Unsigned 32-bit compare; the upper bound is computed at 33 bits so it does not wrap.
//  - FSM states:
//    - RUN:
//      - stall_i = 1: pc, IF/ID and fetch_cnt hold. redirect_i is ignored (the held ID branch
//        re-resolves next cycle).
//      - stall_i = 0 and !bad_pc: IF/ID <= {rom_data_i, pc, pc+8, valid=1}; fetch_cnt += 1.
//        pc <= redirect_i ? redirect_pc_i : pc+4.
//      - stall_i = 0 and bad_pc: IF/ID <= {0, pc, pc+8, valid=0}; fetch_err <= 1; pc holds;
//        state <= HALT.
//    - HALT: pc, fetch_err and fetch_cnt hold. IF/ID keeps the nop with valid=0.
//      stall_i and redirect_i are ignored. Exit only via reset.
//  - Fetch latency: the instruction at pc appears on if_id_* one clock after pc_o shows it.
//  - Delay slot: on a redirect, the word at the current pc (branch+4) still enters IF/ID.
//    The target enters IF/ID one cycle later. No flush output exists.
//  - A redirect to a bad target is accepted into pc; the error is detected the next
//    unstalled cycle.
//  - pc+4 wraps modulo 2^32; the bad_pc check catches it.
//  - fetch_cnt wraps modulo 2^32.
// TESTING
//  1 Reset, then free-run with rom[0..3] = 0x11,0x22,0x33,0x44.
//    -> rom_addr 0,1,2,3.
//    -> IF/ID: (0x3000,0x11), (0x3004,0x22), ...; valid=1; fetch_cnt 1,2,3.
//  2 stall_i=1 for 2 cycles while pc=0x3008.
//    -> pc_o stays 0x3008, rom_addr stays 2; IF/ID stays (0x3004,0x22); fetch_cnt unchanged.
//    -> Resumes with (0x3008,0x33).
//  3 redirect_i=1, redirect_pc_i=0x3020 while pc=0x3004.
//    -> IF/ID gets 0x3004 (delay slot), then 0x3020 with rom[8].
//    -> if_id_pc8 = 0x300C, then 0x3028.
//  4 stall_i=1 and redirect_i=1 (target 0x3100) in the same cycle at pc=0x300C.
//    -> pc stays 0x300C; the next unstalled cycle proceeds normally.
//  5 Redirect to each of 0x3002, 0x2FFC, 0x4000.
//    -> Next cycle: fetch_err=1, if_id_valid=0, if_id_instr=0, pc held, fetch_cnt frozen.
//    -> Stays halted through stall/redirect activity for 10 cycles.
//  6 reset=1 for one cycle while halted, and again mid-stall.
//    -> pc_o=0x3000, fetch_err=0, fetch_cnt=0, valid=0.
//    -> First fetch of rom[0] the following cycle.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// IF-stage controller: owns the PC and the IF/ID register, drives the instruction ROM address,
// applies hazard stalls and ID-stage redirects (MIPS delay slot), and halts on bad PCs.
module instr_fetch_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] ROM_BASE = 32'h0000_3000,
  parameter int unsigned ROM_AW   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [31:0]       rom_data_i,
  output logic [31:0]       pc_o,
  output logic [31:0]       if_id_instr_o,
  output logic [31:0]       if_id_pc_o,
  output logic [31:0]       if_id_pc8_o,
  output logic              if_id_valid_o,
  output logic              fetch_err_o,
  output logic [31:0]       fetch_cnt_o
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;

  // One past the last ROM byte, kept at 33 bits so the bound never wraps.
  localparam logic [32:0] ROM_END = {1'b0, ROM_BASE} + (33'd4 << ROM_AW);

  logic [0:0]  state_r;
  logic [31:0] pc_r;
  logic [31:0] if_id_instr_r;
  logic [31:0] if_id_pc_r;
  logic [31:0] if_id_pc8_r;
  logic        if_id_valid_r;
  logic        fetch_err_r;
  logic [31:0] fetch_cnt_r;
  logic        bad_pc_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] pc_plus8_s;

  // PC decode: fetch legality and sequential successors.
  always_comb begin
    bad_pc_s   = (pc_r[1:0] != 2'b00) || (pc_r < ROM_BASE) || ({1'b0, pc_r} >= ROM_END);
    pc_plus4_s = pc_r + 32'd4;
    pc_plus8_s = pc_r + 32'd8;
  end

  // ROM base is word aligned, so the word offset is a plain subtraction of word indices.
  assign rom_addr_o = pc_r[ROM_AW+1:2] - ROM_BASE[ROM_AW+1:2];

  // PC, IF/ID register, error flag, fetch counter and RUN/HALT state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= RUN;
      pc_r          <= PC_RESET;
      if_id_instr_r <= 32'd0;
      if_id_pc_r    <= PC_RESET;
      if_id_pc8_r   <= PC_RESET + 32'd8;
      if_id_valid_r <= 1'b0;
      fetch_err_r   <= 1'b0;
      fetch_cnt_r   <= 32'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (stall_i) begin
            // Held ID branch re-resolves next cycle, so redirect is dropped here.
            pc_r <= pc_r;
          end else if (!bad_pc_s) begin
            if_id_instr_r <= rom_data_i;
            if_id_pc_r    <= pc_r;
            if_id_pc8_r   <= pc_plus8_s;
            if_id_valid_r <= 1'b1;
            fetch_cnt_r   <= fetch_cnt_r + 32'd1;
            pc_r          <= redirect_i ? redirect_pc_i : pc_plus4_s;
          end else begin
            if_id_instr_r <= 32'd0;
            if_id_pc_r    <= pc_r;
            if_id_pc8_r   <= pc_plus8_s;
            if_id_valid_r <= 1'b0;
            fetch_err_r   <= 1'b1;
            state_r       <= HALT;
          end
        end
        HALT: begin
          if_id_instr_r <= 32'd0;
          if_id_valid_r <= 1'b0;
        end
        default: begin
          // Unreachable encoding: fail safe into HALT with a nop in IF/ID.
          state_r       <= HALT;
          if_id_instr_r <= 32'd0;
          if_id_valid_r <= 1'b0;
          fetch_err_r   <= 1'b1;
        end
      endcase
    end
  end

  assign pc_o          = pc_r;
  assign if_id_instr_o = if_id_instr_r;
  assign if_id_pc_o    = if_id_pc_r;
  assign if_id_pc8_o   = if_id_pc8_r;
  assign if_id_valid_o = if_id_valid_r;
  assign fetch_err_o   = fetch_err_r;
  assign fetch_cnt_o   = fetch_cnt_r;

endmodule
